// File: rtl/conta_param.sv
// conta_param: generic-width, modulo-N up/down counter with a built-in
// prescaler, synchronous load, wrap/saturate boundary mode, a one-cycle
// terminal-count pulse and a sticky overflow flag.
//
// Optional feature macro: CONTA_CAPTURE_EN
//   defined   -> cap_req_i snapshots the current count into cap_val_o and
//                pulses cap_valid_o for one cycle.
//   undefined -> cap_req_i is ignored, cap_val_o and cap_valid_o are tied
//                low and no capture flops exist.
//
// The default parameters give the legacy 3-bit wrapping up-counter.
module conta_param #(
    parameter int WIDTH    = 3,
    parameter int MODULO   = 8,
    parameter int PRESCALE = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             up_i,
    input  logic             sat_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             clr_ovf_i,
    input  logic             cap_req_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tick_o,
    output logic             tc_o,
    output logic             ovf_o,
    output logic [WIDTH-1:0] cap_val_o,
    output logic             cap_valid_o
);

    // Largest legal count value and the last prescaler phase before a step.
    localparam logic [WIDTH-1:0] CountMax = WIDTH'(MODULO - 1);
    localparam logic [15:0]      PreLast  = 16'(PRESCALE - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [15:0]      pre_q, pre_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    logic             tickInt;
    logic             atBoundary;
    logic [WIDTH-1:0] loadClamped;

    // Step strobe: enabled and the prescaler sits on its last phase.
    assign tickInt = en_i && (pre_q == PreLast);

    // The boundary depends on direction: top when counting up, zero when down.
    assign atBoundary = up_i ? (count_q == CountMax) : (count_q == '0);

    // Loaded values above the modulo range are pulled down to the top count.
    assign loadClamped = (load_val_i > CountMax) ? CountMax : load_val_i;

    // Next-state logic: load beats a step; tc/ovf only react to boundary steps.
    always_comb begin
        count_d = count_q;
        pre_d   = pre_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;

        if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end

        if (load_i) begin
            count_d = loadClamped;
            pre_d   = '0;
        end else begin
            if (en_i) begin
                pre_d = tickInt ? 16'd0 : (pre_q + 16'd1);
            end
            if (tickInt) begin
                if (atBoundary) begin
                    tc_d = 1'b1;
                    if (sat_i) begin
                        count_d = count_q;
                    end else begin
                        count_d = up_i ? '0 : CountMax;
                        ovf_d   = 1'b1;
                    end
                end else begin
                    count_d = up_i ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
                end
            end
        end
    end

    // Counter, prescaler and flag registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            pre_q   <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            pre_q   <= pre_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o = count_q;
    assign tick_o  = tickInt;
    assign tc_o    = tc_q;
    assign ovf_o   = ovf_q;

`ifdef CONTA_CAPTURE_EN
    logic [WIDTH-1:0] cap_val_q, cap_val_d;
    logic             cap_valid_q, cap_valid_d;

    // Snapshot the pre-edge count whenever a capture is requested.
    always_comb begin
        cap_val_d   = cap_req_i ? count_q : cap_val_q;
        cap_valid_d = cap_req_i;
    end

    // Capture registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cap_val_q   <= '0;
            cap_valid_q <= 1'b0;
        end else begin
            cap_val_q   <= cap_val_d;
            cap_valid_q <= cap_valid_d;
        end
    end

    assign cap_val_o   = cap_val_q;
    assign cap_valid_o = cap_valid_q;
`else
    logic unusedCapReq;

    assign unusedCapReq = cap_req_i;
    assign cap_val_o    = '0;
    assign cap_valid_o  = 1'b0;
`endif

endmodule

// File: tb/tb_conta_param.sv
// tb_conta_param: directed scoreboard bench for conta_param.
// Three instances cover the default counter (A), WIDTH=4/MODULO=10 (B) and
// PRESCALE=4 (C). Each stimulus vector pushes its hand-computed expected
// post-edge state into a queue; a monitor pops and compares after each edge.
// Capture expectations follow the CONTA_CAPTURE_EN macro.
module tb_conta_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       sat = 1'b0;
    logic       load = 1'b0;
    logic [3:0] loadVal = 4'd0;
    logic       clrOvf = 1'b0;
    logic       capReq = 1'b0;

    logic [2:0] countA, capValA;
    logic       tickA, tcA, ovfA, capValidA;
    logic [3:0] countB, capValB;
    logic       tickB, tcB, ovfB, capValidB;
    logic [2:0] countC, capValC;
    logic       tickC, tcC, ovfC, capValidC;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         sel;
        logic [3:0] count;
        logic       tick;
        logic       tc;
        logic       ovf;
        logic       capValid;
        logic [3:0] capVal;
    } expItem_t;

    expItem_t expQ[$];

    conta_param dutA (
        .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .sat_i(sat),
        .load_i(load), .load_val_i(loadVal[2:0]), .clr_ovf_i(clrOvf),
        .cap_req_i(capReq), .count_o(countA), .tick_o(tickA), .tc_o(tcA),
        .ovf_o(ovfA), .cap_val_o(capValA), .cap_valid_o(capValidA)
    );

    conta_param #(.WIDTH(4), .MODULO(10), .PRESCALE(1)) dutB (
        .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .sat_i(sat),
        .load_i(load), .load_val_i(loadVal), .clr_ovf_i(clrOvf),
        .cap_req_i(capReq), .count_o(countB), .tick_o(tickB), .tc_o(tcB),
        .ovf_o(ovfB), .cap_val_o(capValB), .cap_valid_o(capValidB)
    );

    conta_param #(.WIDTH(3), .MODULO(8), .PRESCALE(4)) dutC (
        .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .sat_i(sat),
        .load_i(load), .load_val_i(loadVal[2:0]), .clr_ovf_i(clrOvf),
        .cap_req_i(capReq), .count_o(countC), .tick_o(tickC), .tc_o(tcC),
        .ovf_o(ovfC), .cap_val_o(capValC), .cap_valid_o(capValidC)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Drive one cycle of inputs on the falling edge and queue what the
    // selected instance must show just after the following rising edge.
    task automatic applyStimulus(
        input int sel, input logic r, input logic e, input logic u,
        input logic s, input logic l, input logic [3:0] lv,
        input logic c, input logic cr,
        input logic [3:0] eCount, input logic eTick, input logic eTc,
        input logic eOvf, input logic [3:0] eCapVal
    );
        expItem_t item;
        @(negedge clk);
        rst = r; en = e; up = u; sat = s; load = l; loadVal = lv;
        clrOvf = c; capReq = cr;
        item.sel = sel;
        item.count = eCount;
        item.tick = eTick;
        item.tc = eTc;
        item.ovf = eOvf;
        item.capValid = cr && !r;
        item.capVal = eCapVal;
        expQ.push_back(item);
    endtask

    // One comparison: bumps the counters and reports any difference.
    task automatic checkOutput(input string name, input logic [3:0] actual,
                               input logic [3:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h",
                     name, $time, actual, expected);
        end
    endtask

    // Monitor: after every rising edge, compare the queued expectation
    // against the instance it names.
    initial begin
        expItem_t   item;
        logic [3:0] aCount, aCapVal;
        logic       aTick, aTc, aOvf, aCapValid;
        logic [3:0] eCapVal;
        logic       eCapValid;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                item = expQ.pop_front();
                case (item.sel)
                    0: begin
                        aCount = {1'b0, countA}; aTick = tickA; aTc = tcA;
                        aOvf = ovfA; aCapVal = {1'b0, capValA}; aCapValid = capValidA;
                    end
                    1: begin
                        aCount = countB; aTick = tickB; aTc = tcB;
                        aOvf = ovfB; aCapVal = capValB; aCapValid = capValidB;
                    end
                    default: begin
                        aCount = {1'b0, countC}; aTick = tickC; aTc = tcC;
                        aOvf = ovfC; aCapVal = {1'b0, capValC}; aCapValid = capValidC;
                    end
                endcase
`ifdef CONTA_CAPTURE_EN
                eCapVal = item.capVal;
                eCapValid = item.capValid;
`else
                eCapVal = 4'd0;
                eCapValid = 1'b0;
`endif
                checkOutput($sformatf("dut%0d.count", item.sel), aCount, item.count);
                checkOutput($sformatf("dut%0d.tick", item.sel), {3'b0, aTick}, {3'b0, item.tick});
                checkOutput($sformatf("dut%0d.tc", item.sel), {3'b0, aTc}, {3'b0, item.tc});
                checkOutput($sformatf("dut%0d.ovf", item.sel), {3'b0, aOvf}, {3'b0, item.ovf});
                checkOutput($sformatf("dut%0d.capVal", item.sel), aCapVal, eCapVal);
                checkOutput($sformatf("dut%0d.capValid", item.sel), {3'b0, aCapValid}, {3'b0, eCapValid});
            end
        end
    end

    // Safety net in case the stimulus process never finishes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus with hand-computed expected values.
    initial begin
        // ---- Instance A: defaults (3-bit, modulo 8, no prescale) ----
        //            sel r e u s l lv c cr  cnt tk tc ov cap
        applyStimulus(0, 1,0,1,0,0, 0,0,0,   0, 0, 0, 0, 0);
        for (int i = 1; i <= 7; i++)
            applyStimulus(0, 0,1,1,0,0, 0,0,0, 4'(i), 1, 0, 0, 0);
        applyStimulus(0, 0,1,1,0,0, 0,0,0,   0, 1, 1, 1, 0);
        applyStimulus(0, 0,1,1,0,0, 0,0,0,   1, 1, 0, 1, 0);
        applyStimulus(0, 0,1,1,0,0, 0,0,0,   2, 1, 0, 1, 0);
        applyStimulus(0, 0,0,1,0,0, 0,1,0,   2, 0, 0, 0, 0);
        applyStimulus(0, 0,0,1,0,0, 0,0,0,   2, 0, 0, 0, 0);
        applyStimulus(0, 0,0,1,0,1, 7,0,0,   7, 0, 0, 0, 0);
        // wrap and clear together: set wins
        applyStimulus(0, 0,1,1,0,0, 0,1,0,   0, 1, 1, 1, 0);
        applyStimulus(0, 0,0,1,0,0, 0,1,0,   0, 0, 0, 0, 0);
        // down, saturate at zero: tc on each tick, no ovf
        applyStimulus(0, 0,1,0,1,0, 0,0,0,   0, 1, 1, 0, 0);
        applyStimulus(0, 0,1,0,1,0, 0,0,0,   0, 1, 1, 0, 0);
        applyStimulus(0, 0,1,0,1,0, 0,0,0,   0, 1, 1, 0, 0);
        applyStimulus(0, 0,0,0,1,0, 0,0,0,   0, 0, 0, 0, 0);
        // down wrap from zero
        applyStimulus(0, 0,1,0,0,0, 0,0,0,   7, 1, 1, 1, 0);
        applyStimulus(0, 0,1,0,0,0, 0,0,0,   6, 1, 0, 1, 0);
        // up saturate at top
        applyStimulus(0, 0,0,1,1,1, 7,0,0,   7, 0, 0, 1, 0);
        applyStimulus(0, 0,1,1,1,0, 0,0,0,   7, 1, 1, 1, 0);
        // load beats a boundary tick and raises no tc
        applyStimulus(0, 0,1,1,0,1, 2,0,0,   2, 1, 0, 1, 0);
        // capture coincident with a 3->4 step, then back-to-back
        applyStimulus(0, 0,0,1,0,1, 3,0,0,   3, 0, 0, 1, 0);
        applyStimulus(0, 0,1,1,0,0, 0,0,1,   4, 1, 0, 1, 3);
        applyStimulus(0, 0,0,1,0,0, 0,0,1,   4, 0, 0, 1, 4);
        applyStimulus(0, 0,0,1,0,0, 0,0,0,   4, 0, 0, 1, 4);
        // reset with load and tick active from count 6
        applyStimulus(0, 0,0,1,0,1, 6,0,0,   6, 0, 0, 1, 4);
        applyStimulus(0, 1,1,1,0,1, 3,0,0,   0, 1, 0, 0, 0);

        // ---- Instance B: WIDTH=4, MODULO=10 ----
        applyStimulus(1, 1,0,1,0,0, 0,0,0,   0, 0, 0, 0, 0);
        applyStimulus(1, 0,0,1,0,1,12,0,0,   9, 0, 0, 0, 0);
        applyStimulus(1, 0,1,1,0,0, 0,0,0,   0, 1, 1, 1, 0);
        applyStimulus(1, 0,0,1,0,0, 0,1,0,   0, 0, 0, 0, 0);
        applyStimulus(1, 0,0,1,0,1,15,0,0,   9, 0, 0, 0, 0);
        applyStimulus(1, 0,1,0,0,0, 0,0,0,   8, 1, 0, 0, 0);

        // ---- Instance C: PRESCALE=4 ----
        applyStimulus(2, 1,0,1,0,0, 0,0,0,   0, 0, 0, 0, 0);
        applyStimulus(2, 0,1,1,0,0, 0,0,0,   0, 0, 0, 0, 0);
        applyStimulus(2, 0,1,1,0,0, 0,0,0,   0, 0, 0, 0, 0);
        applyStimulus(2, 0,1,1,0,0, 0,0,0,   0, 1, 0, 0, 0);
        applyStimulus(2, 0,1,1,0,0, 0,0,0,   1, 0, 0, 0, 0);
        applyStimulus(2, 0,1,1,0,0, 0,0,0,   1, 0, 0, 0, 0);
        applyStimulus(2, 0,1,1,0,1, 5,0,0,   5, 0, 0, 0, 0);
        applyStimulus(2, 0,1,1,0,0, 0,0,0,   5, 0, 0, 0, 0);
        applyStimulus(2, 0,1,1,0,0, 0,0,0,   5, 0, 0, 0, 0);
        applyStimulus(2, 0,1,1,0,0, 0,0,0,   5, 1, 0, 0, 0);
        applyStimulus(2, 0,1,1,0,0, 0,0,0,   6, 0, 0, 0, 0);
        applyStimulus(2, 0,1,1,0,0, 0,0,0,   6, 0, 0, 0, 0);
        // en low: prescaler holds its phase
        applyStimulus(2, 0,0,1,0,0, 0,0,0,   6, 0, 0, 0, 0);
        applyStimulus(2, 0,1,1,0,0, 0,0,0,   6, 0, 0, 0, 0);
        applyStimulus(2, 0,1,1,0,0, 0,0,0,   6, 1, 0, 0, 0);
        applyStimulus(2, 0,1,1,0,0, 0,0,0,   7, 0, 0, 0, 0);
        applyStimulus(2, 0,1,1,0,0, 0,0,0,   7, 0, 0, 0, 0);
        applyStimulus(2, 0,1,1,0,0, 0,0,0,   7, 0, 0, 0, 0);
        applyStimulus(2, 0,1,1,0,0, 0,0,0,   7, 1, 0, 0, 0);
        applyStimulus(2, 0,1,1,0,0, 0,0,0,   0, 0, 1, 1, 0);

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        #2;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", expQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
